// File: rtl/prog_clkdiv_if.sv
// Bus bundle for prog_clkdiv: run requests, divisor config strobe and the
// per-channel divided-clock status outputs.
//   master : drives en/cfg_*, observes clk_out/tick/active/pending
//   slave  : the divider itself
interface prog_clkdiv_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] pending;

  modport master (
    output en, cfg_wr, cfg_ch, cfg_div,
    input  clk_out, tick, active, pending
  );

  modport slave (
    input  en, cfg_wr, cfg_ch, cfg_div,
    output clk_out, tick, active, pending
  );
endinterface

// File: rtl/prog_clkdiv.sv
// Multi-channel programmable clock divider in the 2 MHz domain.
// Each channel divides by div_act (2..2^DIV_W-1), high for ceil(D/2) cycles,
// and pulses tick on the first cycle of every period. Divisor updates and
// enable changes are applied only at the wrap edge, so no runt pulses occur.
// Ports:
//   clk2MHz : clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : prog_clkdiv_if.slave (en, cfg_wr/cfg_ch/cfg_div in;
//             clk_out, tick, active, pending out, all registered)
module prog_clkdiv #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 2
) (
  input logic          clk2MHz,
  input logic          reset,
  prog_clkdiv_if.slave bus
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(2);

  // Divisors 0 and 1 are not meaningful; force them to the minimum of 2.
  logic [DIV_W-1:0] cfg_div_c;
  assign cfg_div_c = (bus.cfg_div < MIN_D) ? MIN_D : bus.cfg_div;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dact_q, dact_d;
    logic [DIV_W-1:0] dpend_q, dpend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             act_q, act_d;
    logic             pend_q, pend_d;
    logic             hit_c, wrap_c;
    logic [DIV_W-1:0] hi_c, cnt_inc_c;

    // Out-of-range cfg_ch matches no channel, so such writes vanish.
    assign hit_c     = bus.cfg_wr && (32'(bus.cfg_ch) == 32'(i));
    assign wrap_c    = (cnt_q == dact_q - DIV_W'(1));
    assign hi_c      = dact_q - (dact_q >> 1);
    assign cnt_inc_c = cnt_q + DIV_W'(1);

    // Next-state: period boundary applies pending divisor and samples en.
    always_comb begin
      cnt_d   = cnt_q;
      dact_d  = dact_q;
      dpend_d = dpend_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      act_d   = act_q;
      pend_d  = pend_q;
      if (wrap_c) begin
        dact_d = dpend_q;
        pend_d = 1'b0;
        if (bus.en[i]) begin
          cnt_d  = '0;
          clk_d  = 1'b1;
          tick_d = 1'b1;
          act_d  = 1'b1;
        end else begin
          // Idle parks the counter at the wrap point of the new divisor.
          cnt_d = dpend_q - DIV_W'(1);
          clk_d = 1'b0;
          act_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_inc_c;
        clk_d = (cnt_inc_c < hi_c);
      end
      // A write on the wrap edge lands in dpend after the old value was taken.
      if (hit_c) begin
        dpend_d = cfg_div_c;
        pend_d  = 1'b1;
      end
    end

    // State register.
    always_ff @(posedge clk2MHz or posedge reset) begin
      if (reset) begin
        cnt_q   <= DEF_D - DIV_W'(1);
        dact_q  <= DEF_D;
        dpend_q <= DEF_D;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        act_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        dact_q  <= dact_d;
        dpend_q <= dpend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        act_q   <= act_d;
        pend_q  <= pend_d;
      end
    end

    assign bus.clk_out[i] = clk_q;
    assign bus.tick[i]    = tick_q;
    assign bus.active[i]  = act_q;
    assign bus.pending[i] = pend_q;
  end

endmodule

// File: tb/tb_prog_clkdiv.sv
// Scoreboard bench for prog_clkdiv. The driver applies one input set per
// cycle and pushes the expected post-edge outputs, taken from a waveform
// model: at each period start the whole period (ceil(D/2) high samples then
// low samples, tick on the first) is queued per channel and consumed one
// sample per edge; an empty queue marks a period boundary.
`timescale 1ns/1ps
module tb_prog_clkdiv;
  localparam int unsigned NC = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned DEFD = 2;

  typedef struct packed {
    logic [NC-1:0] clk;
    logic [NC-1:0] tick;
    logic [NC-1:0] act;
    logic [NC-1:0] pend;
  } exp_t;

  logic clk2MHz = 1'b0;
  logic reset;

  prog_clkdiv_if #(.NUM_CH(NC), .DIV_W(DW)) bus ();

  prog_clkdiv #(.NUM_CH(NC), .DIV_W(DW), .DEF_DIV(DEFD)) dut (
    .clk2MHz(clk2MHz),
    .reset  (reset),
    .bus    (bus)
  );

  always #250 clk2MHz = ~clk2MHz;

  exp_t          sbq[$];
  logic [1:0]    wq[NC][$];
  int unsigned   dact[NC];
  int unsigned   dpend[NC];
  bit            pend[NC];
  logic [NC-1:0] en_v;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      wq[i].delete();
      dact[i]  = DEFD;
      dpend[i] = DEFD;
      pend[i]  = 1'b0;
    end
  endtask

  // Called at a negedge: drive inputs for the next rising edge, queue the
  // expected result, then advance to the following negedge.
  task automatic step(input bit w, input int unsigned c, input int unsigned d);
    exp_t x;
    logic [1:0] s;
    int unsigned hi;
    x = '0;
    bus.en      = en_v;
    bus.cfg_wr  = w;
    bus.cfg_ch  = CW'(c);
    bus.cfg_div = DW'(d);
    for (int i = 0; i < NC; i++) begin
      if (wq[i].size() == 0) begin
        dact[i] = dpend[i];
        pend[i] = 1'b0;
        if (en_v[i]) begin
          hi = dact[i] - dact[i] / 2;
          for (int k = 0; k < int'(dact[i]); k++)
            wq[i].push_back({(k < int'(hi)), (k == 0)});
        end
      end
      if (wq[i].size() > 0) begin
        s = wq[i].pop_front();
        x.clk[i]  = s[1];
        x.tick[i] = s[0];
        x.act[i]  = 1'b1;
      end
      if (w && c == i) begin
        dpend[i] = (d < 2) ? 2 : d;
        pend[i]  = 1'b1;
      end
      x.pend[i] = pend[i];
    end
    sbq.push_back(x);
    @(negedge clk2MHz);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_clk_out"}, bus.clk_out, '0);
    chk({nm, "_tick"},    bus.tick,    '0);
    chk({nm, "_active"},  bus.active,  '0);
    chk({nm, "_pending"}, bus.pending, '0);
  endtask

  // Monitor: every rising edge with an outstanding expectation is checked.
  always @(posedge clk2MHz) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("clk_out", bus.clk_out, e.clk);
      chk("tick",    bus.tick,    e.tick);
      chk("active",  bus.active,  e.act);
      chk("pending", bus.pending, e.pend);
    end
  end

  initial begin
    reset       = 1'b1;
    en_v        = '0;
    bus.en      = '0;
    bus.cfg_wr  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    model_reset();
    repeat (3) @(negedge clk2MHz);
    check_zero("reset");
    reset = 1'b0;

    // 1 MHz legacy output on channel 0 with reset divisor
    en_v = 5'b00001;
    run(8);

    // divide by 5 on channel 1
    step(1'b1, 1, 5);
    en_v[1] = 1'b1;
    run(16);

    // channel 2 at 4, reprogrammed to 6 mid-period
    step(1'b1, 2, 4);
    en_v[2] = 1'b1;
    run(5);
    step(1'b1, 2, 6);
    run(14);

    // channel 3 at 8, disabled mid-period
    step(1'b1, 3, 8);
    en_v[3] = 1'b1;
    run(11);
    en_v[3] = 1'b0;
    run(12);

    // clamped divisors and out-of-range channel writes
    step(1'b1, 0, 0);
    step(1'b1, 1, 1);
    step(1'b1, 5, 9);
    step(1'b1, 6, 9);
    step(1'b1, 7, 9);
    run(12);

    // back-to-back writes: the last one before the wrap wins
    step(1'b1, 4, 7);
    step(1'b1, 4, 3);
    en_v[4] = 1'b1;
    run(12);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) en_v[$urandom_range(0, NC-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 15) == 0) step(1'b1, $urandom_range(0, 7), $urandom_range(240, 255));
        else                            step(1'b1, $urandom_range(0, 7), $urandom_range(0, 12));
      end else begin
        step(1'b0, 0, 0);
      end
    end

    // asynchronous reset mid-period on all channels
    en_v = '1;
    for (int i = 0; i < NC; i++) step(1'b1, i, 2 + i);
    run(7);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk2MHz);
    reset = 1'b0;
    run(20);

    @(posedge clk2MHz);
    #2;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
